// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, branch flush and operand forwarding control
// for the in-order pipeline. A shift register of instruction tags follows
// every instruction from EX through the last writeback stage; all
// hazard decisions are made by comparing the ID and EX source registers
// against the destinations held in that shift register.
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4,
    parameter int LOAD_READY = 2,
    parameter int BR_STAGE   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs,
    input  logic [REG_ADDR_W-1:0]    id_rt,
    input  logic                     id_use_rs,
    input  logic                     id_use_rt,
    input  logic                     id_wr_en,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic                     id_is_load,
    input  logic                     br_taken,
    input  logic                     cnt_clr,
    output logic                     stall,
    output logic                     flush,
    output logic [$clog2(DEPTH)-1:0] fwd_a,
    output logic [$clog2(DEPTH)-1:0] fwd_b,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam int FWD_W = $clog2(DEPTH);

    // Elaboration-time guards on the pipeline geometry.
    if (DEPTH < 3) begin : g_bad_depth
        $error("hazard_unit: DEPTH must be at least 3");
    end
    if (LOAD_READY < 1 || LOAD_READY >= DEPTH) begin : g_bad_load_ready
        $error("hazard_unit: LOAD_READY must satisfy 1 <= LOAD_READY < DEPTH");
    end
    if (BR_STAGE < 1 || BR_STAGE >= DEPTH) begin : g_bad_br_stage
        $error("hazard_unit: BR_STAGE must satisfy 1 <= BR_STAGE < DEPTH");
    end

    // Tag record for one in-flight instruction.
    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  use_rs;
        logic                  use_rt;
    } entry_t;

    typedef entry_t [DEPTH-1:0] entry_vec_t;

    // ent[0] is EX, ent[1] is MEM, ... ent[DEPTH-1] is the last writeback stage.
    entry_vec_t ent;

    logic hazard;

    // True when entry e will write register r. r0 is hardwired zero and
    // therefore never produces a match.
    function automatic logic wr_match(input entry_t e, input logic [REG_ADDR_W-1:0] r);
        return e.valid && e.wr_en && (e.rd == r) && (r != '0);
    endfunction

    // Forwarding source for one EX operand: the youngest matching entry
    // wins. A load that matches before its data is ready selects the
    // register-file path instead; that situation is excluded by the stall.
    function automatic logic [FWD_W-1:0] pick_src(
        input entry_vec_t              e,
        input logic                    use_src,
        input logic [REG_ADDR_W-1:0]   r
    );
        logic [FWD_W-1:0] sel;
        logic             found;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if (!found && wr_match(e[k], r)) begin
                found = 1'b1;
                if (!(e[k].is_load && (k < LOAD_READY))) begin
                    sel = FWD_W'(k);
                end
            end
        end
        if (!(e[0].valid && use_src)) begin
            sel = '0;
        end
        return sel;
    endfunction

    // Load-use detection: a used ID source matches a load whose data will
    // not yet be forwardable when the ID instruction reaches EX.
    always_comb begin
        // NOTE: every always_comb output gets a default before any
        // conditional assignment, so no path can leave it holding a value
        // (which would infer a latch).
        hazard = 1'b0;
        for (int j = 0; j < LOAD_READY - 1; j++) begin
            if (ent[j].is_load &&
                ((id_use_rs && wr_match(ent[j], id_rs)) ||
                 (id_use_rt && wr_match(ent[j], id_rt)))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && id_valid;
    end

    // A taken branch kills the younger instructions, so it overrides a stall.
    assign flush = br_taken;
    assign stall = hazard && !br_taken;

    // Operand forwarding selects for the instruction currently in EX.
    always_comb begin
        fwd_a = pick_src(ent, ent[0].use_rs, ent[0].rs);
        fwd_b = pick_src(ent, ent[0].use_rt, ent[0].rt);
    end

    // Tag shift register: advances every cycle, bubbles on stall/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the tag array is control state, not data storage; it must
            // be cleared on reset so nothing stale forwards or stalls after
            // release.
            ent <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // entry samples its neighbour's pre-edge value regardless of
            // loop order.
            for (int k = 0; k < DEPTH - 1; k++) begin
                ent[k+1] <= ent[k];
                if (flush && (k < BR_STAGE)) begin
                    ent[k+1].valid <= 1'b0;
                end
            end
            if (stall || flush || !id_valid) begin
                ent[0] <= '0;
            end else begin
                ent[0].valid   <= 1'b1;
                ent[0].wr_en   <= id_wr_en;
                ent[0].rd      <= id_rd;
                ent[0].is_load <= id_is_load;
                ent[0].rs      <= id_rs;
                ent[0].rt      <= id_rt;
                ent[0].use_rs  <= id_use_rs;
                ent[0].use_rt  <= id_use_rt;
            end
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Saturating flush counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            flush_cnt <= '0;
        end else if (flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Source tags of the oldest entry are carried for uniformity but never
    // compared; fold them into a sink so they do not read as dead logic.
    logic unused_tail;
    assign unused_tail = ^{ent[DEPTH-1].rs, ent[DEPTH-1].rt,
                           ent[DEPTH-1].use_rs, ent[DEPTH-1].use_rt};

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors for hazard_unit with hand-computed
// expectations. Inputs change just after the falling edge; outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_hazard_unit;

    localparam int RW    = 5;
    localparam int DEPTH = 4;
    localparam int FW    = $clog2(DEPTH);
    localparam int CW    = 4;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_wr_en;
    logic [RW-1:0] id_rd;
    logic          id_is_load;
    logic          br_taken;
    logic          cnt_clr;
    logic          stall;
    logic          flush;
    logic [FW-1:0] fwd_a;
    logic [FW-1:0] fwd_b;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_stall_seen;

    hazard_unit #(
        .REG_ADDR_W (RW),
        .DEPTH      (DEPTH),
        .LOAD_READY (2),
        .BR_STAGE   (1),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wr_en   (id_wr_en),
        .id_rd      (id_rd),
        .id_is_load (id_is_load),
        .br_taken   (br_taken),
        .cnt_clr    (cnt_clr),
        .stall      (stall),
        .flush      (flush),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present one instruction in ID: (valid, rs, rt, use_rs, use_rt, wr_en, rd, is_load).
    task automatic set_id(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic urs, input logic urt, input logic we,
                          input logic [RW-1:0] rd, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_wr_en   = we;
        id_rd      = rd;
        id_is_load = ld;
    endtask

    task automatic set_nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Advance to the next falling edge; caller then drives inputs and settles.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH; i++) begin
            next_cycle();
            set_nop();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        br_taken = 1'b0;
        cnt_clr  = 1'b0;
        set_nop();

        // Reset state.
        next_cycle();
        settle();
        check("reset_stall", stall, 0);
        check("reset_flush", flush, 0);
        check("reset_fwd_a", fwd_a, 0);
        check("reset_fwd_b", fwd_b, 0);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_flush_cnt", flush_cnt, 0);
        rst_n = 1'b1;

        // ALU chain: add r3,r1,r2 ; sub r4,r3,r1.
        next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0); settle();
        check("alu_add_stall", stall, 0);
        next_cycle(); set_id(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0); settle();
        check("alu_sub_stall", stall, 0);
        next_cycle(); set_nop(); settle();
        check("alu_fwd_a", fwd_a, 1);
        check("alu_fwd_b", fwd_b, 0);
        drain();

        // Load-use: lw r5,(r1) ; add r6,r5,r5.
        next_cycle(); set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1); settle();
        check("lu_lw_stall", stall, 0);
        next_cycle(); set_id(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0); settle();
        check("lu_stall_on", stall, 1);
        next_cycle(); settle();
        check("lu_stall_off", stall, 0);
        check("lu_bubble_fwd_a", fwd_a, 0);
        next_cycle(); set_nop(); settle();
        check("lu_fwd_a", fwd_a, 2);
        check("lu_fwd_b", fwd_b, 2);
        check("lu_stall_cnt", stall_cnt, 1);
        drain();

        // r0 never matches: lw r0 ; add r1,r0,r0 ; add r0,r2,r2 ; add r2,r0,r0.
        next_cycle(); set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 1); settle();
        next_cycle(); set_id(1, 5'd0, 5'd0, 1, 1, 1, 5'd1, 0); settle();
        check("r0_load_stall", stall, 0);
        next_cycle(); set_id(1, 5'd2, 5'd2, 1, 1, 1, 5'd0, 0); settle();
        check("r0_load_fwd_a", fwd_a, 0);
        check("r0_load_fwd_b", fwd_b, 0);
        next_cycle(); set_id(1, 5'd0, 5'd0, 1, 1, 1, 5'd2, 0); settle();
        next_cycle(); set_nop(); settle();
        check("r0_alu_fwd_a", fwd_a, 0);
        check("r0_alu_fwd_b", fwd_b, 0);
        check("r0_stall_cnt", stall_cnt, 1);
        drain();

        // Youngest wins: add r7 (A) ; add r7 (B) ; add r8,r7,r7.
        next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0);
        next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0);
        next_cycle(); set_id(1, 5'd7, 5'd7, 1, 1, 1, 5'd8, 0); settle();
        check("yw_stall", stall, 0);
        next_cycle(); set_nop(); settle();
        check("yw_fwd_a", fwd_a, 1);
        check("yw_fwd_b", fwd_b, 1);
        drain();

        // Same with a nop between B and the consumer.
        next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0);
        next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0);
        next_cycle(); set_nop();
        next_cycle(); set_id(1, 5'd7, 5'd7, 1, 1, 1, 5'd8, 0);
        next_cycle(); set_nop(); settle();
        check("yw_gap_fwd_a", fwd_a, 2);
        check("yw_gap_fwd_b", fwd_b, 2);
        drain();

        // Flush vs stall: add r9 (X) ; lw r5 ; add r6,r5,r5 with br_taken.
        next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd9, 0);
        next_cycle(); set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1);
        next_cycle(); set_id(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0); br_taken = 1'b1; settle();
        check("fl_stall", stall, 0);
        check("fl_flush", flush, 1);
        // Killed lw (old E[0]) and killed ID must never be seen again; X survives.
        next_cycle(); br_taken = 1'b0; set_id(1, 5'd5, 5'd9, 1, 1, 1, 5'd10, 0); settle();
        check("fl_after_stall", stall, 0);
        check("fl_after_flush", flush, 0);
        next_cycle(); set_id(1, 5'd6, 5'd6, 1, 1, 1, 5'd11, 0); settle();
        check("fl_killed_lw_fwd_a", fwd_a, 0);
        check("fl_kept_x_fwd_b", fwd_b, 3);
        next_cycle(); set_nop(); settle();
        check("fl_killed_id_fwd_a", fwd_a, 0);
        check("fl_flush_cnt", flush_cnt, 1);
        drain();

        // Counter saturation: self-dependent loads stall every other cycle.
        n_stall_seen = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle(); set_id(1, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1); settle();
            if (stall) n_stall_seen++;
        end
        check("sat_stall_cycles", n_stall_seen, 20);
        next_cycle(); set_nop(); settle();
        check("sat_stall_cnt", stall_cnt, 15);
        check("sat_flush_cnt", flush_cnt, 1);
        next_cycle(); cnt_clr = 1'b1;
        next_cycle(); cnt_clr = 1'b0; settle();
        check("clr_stall_cnt", stall_cnt, 0);
        check("clr_flush_cnt", flush_cnt, 0);
        drain();

        // Reset mid-operation with live tags and a pending stall.
        next_cycle(); br_taken = 1'b1;
        next_cycle(); br_taken = 1'b0; set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        next_cycle(); set_id(1, 5'd3, 5'd0, 1, 0, 1, 5'd5, 1);
        next_cycle(); set_id(1, 5'd5, 5'd3, 1, 1, 1, 5'd6, 0); settle();
        check("rst_pre_stall", stall, 1);
        check("rst_pre_fwd_a", fwd_a, 1);
        check("rst_pre_flush_cnt", flush_cnt, 1);
        #1 rst_n = 1'b0; br_taken = 1'b1;
        #1;
        check("rst_async_stall", stall, 0);
        check("rst_async_fwd_a", fwd_a, 0);
        check("rst_async_fwd_b", fwd_b, 0);
        check("rst_async_flush", flush, 1);
        check("rst_async_flush_cnt", flush_cnt, 0);
        check("rst_async_stall_cnt", stall_cnt, 0);
        br_taken = 1'b0;
        next_cycle(); rst_n = 1'b1; settle();
        check("rst_rel_stall", stall, 0);
        next_cycle(); set_nop(); settle();
        check("rst_rel_fwd_a", fwd_a, 0);
        check("rst_rel_fwd_b", fwd_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard, forwarding and flush controller for the in-order processor pipeline. It tracks destination and source register tags for every instruction from EX through the last writeback stage. It drives load-use stalls, branch flushes and per-operand forwarding selects to the datapath. It also keeps saturating stall and flush event counters.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width.
- DEPTH, 4, number of tracked stages; entry 0 = EX, 1 = MEM, 2 = WB, 3 = WB_END; must be ≥3.
- LOAD_READY, 2, first entry index whose load result is forwardable; 1 ≤ LOAD_READY < DEPTH.
- BR_STAGE, 1, entry index at which branches resolve; 1 ≤ BR_STAGE < DEPTH.
- CNT_W, 16, event counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  ID source register addresses.
- id_use_rs, id_use_rt  in  1  ID instruction reads the corresponding source.
- id_wr_en  in  1  ID instruction writes a register.
- id_rd  in  REG_ADDR_W  ID destination register, already muxed rd/rt.
- id_is_load  in  1  ID instruction is a load.
- br_taken  in  1  branch in entry BR_STAGE is taken this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush  out  1  kill IF/ID and entries 0..BR_STAGE-1.
- fwd_a, fwd_b  out  $clog2(DEPTH)  EX operand source; 0 = regfile/ID/EX value, k = result held by entry k.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

## Operation
- Entry E[k] fields: valid, wr_en, rd, is_load, rs, rt, use_rs, use_rt.
- Write-match M(k,r): E[k].valid & E[k].wr_en & E[k].rd==r & r!=0.
- Load-use hazard H: id_valid, and there exist j < LOAD_READY-1 and a used ID source r with M(j,r) & E[j].is_load.
- stall = H & ~br_taken.
- flush = br_taken. Flush overrides stall in the same cycle.
- Forwarding for the EX instruction:
  - fwd_a = smallest k in 1..DEPTH-1 with E[0].use_rs & M(k,E[0].rs); 0 if no match or E[0] is invalid.
  - fwd_b is computed the same way on rt/use_rt.
  - The youngest match wins.
  - A match on a load entry with k < LOAD_READY cannot occur after a correct stall. If it does occur, select 0.
- Register r0 never matches, so it always forwards from 0.
- Shift every cycle, with no global enable:
  - E[k+1] ← E[k].
  - If flush and k < BR_STAGE, the shifted-in entry has valid=0.
- Entry 0 load:
  - E[0] ← bubble (valid=0) if stall, flush or ~id_valid.
  - Otherwise E[0] ← ID fields.
- Entries older than BR_STAGE are never affected by flush.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with flush=1.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr has priority over increment: it forces both counters to 0 on that edge.

## Timing
- stall, flush, fwd_a and fwd_b are combinational from current state and inputs. They are valid within the same cycle.
- Load-use stall latency: LOAD_READY-1 bubble cycles for a dependent instruction directly behind a load. The default is 1.
- A dependent ALU instruction directly behind its producer sees fwd=1 in EX with zero stall.
- Reset values (asynchronous on rst_n=0):
  - All entry fields 0, so stall=0, fwd_a=fwd_b=0, counters 0.
  - flush follows br_taken.
- Reset mid-operation discards all in-flight tags immediately. No stale forwarding occurs on the first cycle after release.
- A stalled ID instruction re-evaluates H every cycle. stall drops in the cycle the load reaches entry LOAD_READY-1.

## Test plan
- ALU chain (defaults): ID add r3,r1,r2, then ID sub r4,r3,r1 next cycle -> no stall; when sub is in EX, fwd_a=1, fwd_b=0.
- Load-use: lw r5 followed by add r6,r5,r5 -> stall=1 for exactly 1 cycle, E[0] bubble; add enters EX with fwd_a=fwd_b=2; stall_cnt=1.
- r0 writes: lw r0 followed by add r1,r0,r0 -> stall=0 and fwd=0 throughout.
- Youngest wins:
  - Sequence: add r7 (A), add r7 (B), add r8,r7,r7.
  - Required: fwd_a=fwd_b=1, selecting B not A.
  - Repeat with a nop between B and the consumer -> fwd=2.
- Flush vs stall: br_taken=1 in the same cycle as a load-use hazard -> stall=0, flush=1; next cycle E[1] valid=0 and E[0] valid=0; entries ≥2 unchanged; flush_cnt=1.
- Counters and reset:
  - With CNT_W=4, drive 20 stall cycles -> stall_cnt=15; cnt_clr -> 0.
  - Assert rst_n=0 mid-sequence with valid entries -> all outputs at reset values asynchronously, with no forwarding after release.
